// File: rtl/decoder_scan_driver_if.sv
// Handshake/status bundle between a scan controller and the decoder scan driver.
// The controller side uses master; the driver uses slave.
interface decoder_scan_driver_if #(
  parameter int NUM_OF_BITS = 4
);
  logic                   start;
  logic                   stop;
  logic                   continuous;
  logic [NUM_OF_BITS-1:0] a;
  logic                   ena;
  logic                   busy;
  logic                   done;
  logic                   wrap;

  modport master (
    output start, stop, continuous,
    input  a, ena, busy, done, wrap
  );

  modport slave (
    input  start, stop, continuous,
    output a, ena, busy, done, wrap
  );
endinterface

// File: rtl/decoder_scan_driver.sv
// Steps the select code of a 2**NUM_OF_BITS-way decoder through every value,
// holding each one for DWELL_CYCLES clocks, in single-sweep or continuous mode.
//
// state | meaning
// IDLE  | waiting for start; a=0, ena=0
// SCAN  | sweeping codes, ena=1, busy=1
// DONE  | one-cycle done pulse after a completed single sweep
module decoder_scan_driver #(
  parameter int NUM_OF_BITS  = 4,
  parameter int DWELL_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  decoder_scan_driver_if.slave bus
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]          DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]          DWELL_ONE  = CW'(1);
  localparam logic [NUM_OF_BITS-1:0] CODE_LAST  = '1;
  localparam logic [NUM_OF_BITS-1:0] CODE_ONE   = NUM_OF_BITS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          dwell_cnt;
  logic                   mode_cont;
  logic [NUM_OF_BITS-1:0] a_q;
  logic                   ena_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   wrap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      mode_cont <= 1'b0;
      a_q       <= '0;
      ena_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state     <= SCAN;
            a_q       <= '0;
            ena_q     <= 1'b1;
            busy_q    <= 1'b1;
            dwell_cnt <= '0;
            mode_cont <= bus.continuous;
          end
        end
        SCAN: begin
          // stop beats both the end-of-sweep done and the continuous wrap
          if (bus.stop) begin
            state     <= IDLE;
            a_q       <= '0;
            ena_q     <= 1'b0;
            busy_q    <= 1'b0;
            dwell_cnt <= '0;
          end else if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (a_q != CODE_LAST) begin
              a_q <= a_q + CODE_ONE;
            end else if (mode_cont) begin
              a_q    <= '0;
              wrap_q <= 1'b1;
            end else begin
              state  <= DONE;
              a_q    <= '0;
              ena_q  <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_ONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.a    = a_q;
  assign bus.ena  = ena_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;

endmodule

// File: doc/decoder_scan_driver.md
Name: decoder_scan_driver

Overview:
- Sequential address generator that sits directly upstream of the 4-to-16 gate-level decoder.
- Drives the decoder's select code and enable, stepping through every code 0..2**NUM_OF_BITS-1.
- Holds each code for a programmable number of cycles, for row/column or LED scanning.
- Supports a single-sweep mode and a continuous mode, with start/stop control and a done pulse.

Parameters:
- NUM_OF_BITS, 4, width of the select code; the sweep covers codes 0..2**NUM_OF_BITS-1.
- DWELL_CYCLES, 4, clock cycles each code is held with enable high; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  level-sampled request to begin a sweep; honoured only in IDLE.
- stop  input  1  abort request; honoured in SCAN.
- continuous  input  1  sampled with start: 1 = wrap and repeat forever, 0 = single sweep.
- a  output  NUM_OF_BITS  select code to the decoder; registered.
- ena  output  1  decoder enable; registered; high only in SCAN.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse at the end of a completed single sweep.
- wrap  output  1  one-cycle pulse when a continuous sweep wraps from the last code to 0.

Behaviour:
- Reset (async assert, any time): state=IDLE, a=0, ena=0, busy=0, done=0, wrap=0, dwell counter=0, mode register=0.
- All outputs are registered; there is no combinational path from any input to any output.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 and stop=0 at edge k: after edge k, state=SCAN, a=0, ena=1, busy=1, dwell counter=0, mode latched from continuous.
  - start=1 and stop=1 together: stop wins; remain IDLE.
- SCAN:
  - Dwell counter increments every cycle.
  - At counter==DWELL_CYCLES-1 the counter clears and the code advances.
  - If a < 2**NUM_OF_BITS-1: a <= a+1.
  - If a == 2**NUM_OF_BITS-1 and mode=continuous: a <= 0, wrap pulses for exactly the cycle a first shows 0; stay in SCAN.
  - If a == 2**NUM_OF_BITS-1 and mode=single: state <= DONE, ena <= 0, busy <= 0, a <= 0, done <= 1.
  - Each code is visible with ena=1 for exactly DWELL_CYCLES cycles.
  - A single sweep keeps ena high for exactly 2**NUM_OF_BITS*DWELL_CYCLES cycles.
- stop=1 sampled in SCAN: next cycle state=IDLE, a=0, ena=0, busy=0. No done or wrap pulse. Stop takes priority over a simultaneous end-of-sweep or wrap.
- DONE: lasts one cycle (done=1), then IDLE. start during DONE is ignored; start is honoured from IDLE on the following cycle.
- start while busy: ignored. continuous is not re-sampled mid-sweep.
- DWELL_CYCLES=1: a changes every cycle; the counter is always 0.
- The a increment is modulo 2**NUM_OF_BITS; there is no out-of-range code.
- Reset asserted mid-sweep: outputs go to reset values immediately (asynchronously). After deassertion the block waits in IDLE for a new start.

Test Plan:
- Reset: rst=1 mid-SCAN with a=7 -> a=0, ena=0, busy=0 before the next clk edge; stays IDLE after release until start.
- Single sweep: N=4, D=4, start=1 for one cycle, continuous=0 -> a=0..15, each held 4 cycles with ena=1 (64 cycles), then done=1 for 1 cycle, a=0, ena=0, busy=0.
- Continuous: continuous=1 -> after a=15 has been held 4 cycles, a=0 with wrap=1 for 1 cycle, ena stays 1, done never pulses; three full wraps are checked.
- Abort: stop=1 while a=9 in its 2nd dwell cycle -> next cycle a=0, ena=0, busy=0, no done; a start 1 cycle later restarts at a=0.
- Edge cases: start and stop together in IDLE -> stays IDLE. start during SCAN -> sequence unchanged. With D=1 -> a increments every cycle, done after 16 ena cycles.
- Decoder integration: drive the 4-to-16 decoder from a/ena -> exactly one hot bit at out[a] whenever ena=1, out all zero otherwise.
